// File: rtl/fabric_mem_pkg.sv
// Shared constants for the fabric word memory tile.
// Error codes and default geometry.
package fabric_mem_pkg;

    localparam int DEFAULT_DEPTH      = 64;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 64;

    localparam logic [15:0] ERR_NONE   = 16'h0000;
    localparam logic [15:0] ERR_LD_OOB = 16'h0001;
    localparam logic [15:0] ERR_ST_OOB = 16'h0002;

endpackage

// File: rtl/fabric_out_slot.sv
// One-entry output register for a valid/ready stream.
// Ports: push/push_data load the slot, free reports it can take a push
// this cycle, out_valid/out_ready/out_data form the downstream stream.
module fabric_out_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         free,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Free when empty or when the held entry leaves on this edge.
    assign free      = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/memory_top.sv
// Word memory tile: load and store streams with completion tokens.
// Ports: ldaddr/staddr/stdata in, lddata/lddone/stdone out, sticky error.
module memory_top
    import fabric_mem_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ldaddr_valid,
    output logic                  ldaddr_ready,
    input  logic [ADDR_WIDTH-1:0] ldaddr_data,
    input  logic                  staddr_valid,
    output logic                  staddr_ready,
    input  logic [ADDR_WIDTH-1:0] staddr_data,
    input  logic                  stdata_valid,
    output logic                  stdata_ready,
    input  logic [DATA_WIDTH-1:0] stdata_data,
    output logic                  lddata_valid,
    input  logic                  lddata_ready,
    output logic [DATA_WIDTH-1:0] lddata_data,
    output logic                  lddone_valid,
    input  logic                  lddone_ready,
    output logic [0:0]            lddone_data,
    output logic                  stdone_valid,
    input  logic                  stdone_ready,
    output logic [0:0]            stdone_data,
    output logic                  error_valid,
    output logic [15:0]           error_code
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  err_valid_q, err_valid_d;
    logic [15:0]           err_code_q, err_code_d;

    logic                  lddata_free, lddone_free, stdone_free;
    logic                  ld_fire, st_fire;
    logic                  ld_in_range, st_in_range;
    logic [IDX_W-1:0]      ld_idx, st_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    // Full-width compare so high address bits cannot alias into range.
    assign ld_in_range = ldaddr_data < ADDR_WIDTH'(DEPTH);
    assign st_in_range = staddr_data < ADDR_WIDTH'(DEPTH);
    assign ld_idx      = ldaddr_data[IDX_W-1:0];
    assign st_idx      = staddr_data[IDX_W-1:0];

    assign ldaddr_ready = lddata_free && lddone_free;
    assign staddr_ready = stdone_free;
    assign stdata_ready = stdone_free;

    assign ld_fire = ldaddr_valid && ldaddr_ready;
    // A store needs both halves; neither stream advances alone.
    assign st_fire = staddr_valid && stdata_valid && stdone_free;

    // Reads come from the registered array, so a same-edge store is
    // not visible to the load (read-first).
    assign rd_data = ld_in_range ? mem_q[ld_idx] : '0;

    always_comb begin
        mem_d = mem_q;
        if (st_fire && st_in_range) begin
            mem_d[st_idx] = stdata_data;
        end
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        if (!err_valid_q) begin
            if (ld_fire && !ld_in_range) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_LD_OOB;
            end else if (st_fire && !st_in_range) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_ST_OOB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            mem_q       <= mem_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign error_valid = err_valid_q;
    assign error_code  = err_code_q;

    fabric_out_slot #(.W(DATA_WIDTH)) u_lddata (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_fire),
        .push_data (rd_data),
        .free      (lddata_free),
        .out_valid (lddata_valid),
        .out_ready (lddata_ready),
        .out_data  (lddata_data)
    );

    fabric_out_slot #(.W(1)) u_lddone (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_fire),
        .push_data (1'b0),
        .free      (lddone_free),
        .out_valid (lddone_valid),
        .out_ready (lddone_ready),
        .out_data  (lddone_data)
    );

    fabric_out_slot #(.W(1)) u_stdone (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (st_fire),
        .push_data (1'b0),
        .free      (stdone_free),
        .out_valid (stdone_valid),
        .out_ready (stdone_ready),
        .out_data  (stdone_data)
    );

endmodule

// File: tb/tb_memory_top.sv
// Self-checking bench for memory_top: directed scenarios plus random
// traffic compared against a behavioural memory/stream model.
module tb_memory_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ldaddr_valid = 1'b0;
    logic        ldaddr_ready;
    logic [63:0] ldaddr_data = '0;
    logic        staddr_valid = 1'b0;
    logic        staddr_ready;
    logic [63:0] staddr_data = '0;
    logic        stdata_valid = 1'b0;
    logic        stdata_ready;
    logic [31:0] stdata_data = '0;
    logic        lddata_valid;
    logic        lddata_ready = 1'b1;
    logic [31:0] lddata_data;
    logic        lddone_valid;
    logic        lddone_ready = 1'b1;
    logic [0:0]  lddone_data;
    logic        stdone_valid;
    logic        stdone_ready = 1'b1;
    logic [0:0]  stdone_data;
    logic        error_valid;
    logic [15:0] error_code;

    memory_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ldaddr_valid (ldaddr_valid),
        .ldaddr_ready (ldaddr_ready),
        .ldaddr_data  (ldaddr_data),
        .staddr_valid (staddr_valid),
        .staddr_ready (staddr_ready),
        .staddr_data  (staddr_data),
        .stdata_valid (stdata_valid),
        .stdata_ready (stdata_ready),
        .stdata_data  (stdata_data),
        .lddata_valid (lddata_valid),
        .lddata_ready (lddata_ready),
        .lddata_data  (lddata_data),
        .lddone_valid (lddone_valid),
        .lddone_ready (lddone_ready),
        .lddone_data  (lddone_data),
        .stdone_valid (stdone_valid),
        .stdone_ready (stdone_ready),
        .stdone_data  (stdone_data),
        .error_valid  (error_valid),
        .error_code   (error_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: memory contents, pending outputs, error state.
    bit [31:0] m_mem [64];
    bit        m_ldv, m_ldd, m_stv;
    bit [31:0] m_lddata;
    bit        m_errv;
    bit [15:0] m_errc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_ldv    = 0;
        m_ldd    = 0;
        m_stv    = 0;
        m_lddata = '0;
        m_errv   = 0;
        m_errc   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        ldaddr_valid = 1'b0;
        staddr_valid = 1'b0;
        stdata_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare outputs with the model, then
    // advance the model by whatever transfers happen at the edge.
    task automatic cycle(input bit lv, input logic [63:0] la,
                         input bit sav, input logic [63:0] sa,
                         input bit sdv, input logic [31:0] sd,
                         input bit ldr, input bit ddr, input bit sdr);
        bit        ld_rdy, st_rdy, ld_fire, st_fire;
        bit [31:0] rd;
        @(negedge clk);
        ldaddr_valid = lv;
        ldaddr_data  = la;
        staddr_valid = sav;
        staddr_data  = sa;
        stdata_valid = sdv;
        stdata_data  = sd;
        lddata_ready = ldr;
        lddone_ready = ddr;
        stdone_ready = sdr;
        #1;
        ld_rdy = (!m_ldv || ldr) && (!m_ldd || ddr);
        st_rdy = !m_stv || sdr;
        chk("ldaddr_ready", ldaddr_ready, ld_rdy);
        chk("staddr_ready", staddr_ready, st_rdy);
        chk("stdata_ready", stdata_ready, st_rdy);
        chk("lddata_valid", lddata_valid, m_ldv);
        chk("lddata_data", lddata_data, m_lddata);
        chk("lddone_valid", lddone_valid, m_ldd);
        chk("stdone_valid", stdone_valid, m_stv);
        chk("done_data", {lddone_data, stdone_data}, 2'b00);
        chk("error_valid", error_valid, m_errv);
        chk("error_code", error_code, m_errc);
        ld_fire = lv && ld_rdy;
        st_fire = sav && sdv && st_rdy;
        @(posedge clk);
        rd = (la < 64) ? m_mem[la[5:0]] : 32'h0;
        if (ld_fire) begin
            m_ldv    = 1;
            m_ldd    = 1;
            m_lddata = rd;
        end else begin
            if (ldr) m_ldv = 0;
            if (ddr) m_ldd = 0;
        end
        if (st_fire) begin
            m_stv = 1;
            if (sa < 64) m_mem[sa[5:0]] = sd;
        end else if (sdr) begin
            m_stv = 0;
        end
        if (!m_errv) begin
            if (ld_fire && la >= 64) begin
                m_errv = 1;
                m_errc = 16'h0001;
            end else if (st_fire && sa >= 64) begin
                m_errv = 1;
                m_errc = 16'h0002;
            end
        end
    endtask

    task automatic idle(input bit ldr, input bit ddr, input bit sdr);
        cycle(0, 64'd0, 0, 64'd0, 0, 32'd0, ldr, ddr, sdr);
    endtask

    task automatic rand_addr(output logic [63:0] a);
        int r;
        r = $urandom_range(0, 39);
        if (r == 0)      a = 64'd64 + 64'($urandom_range(0, 40));
        else if (r == 1) a = {$urandom, $urandom} | 64'h1_0000_0000;
        else             a = 64'($urandom_range(0, 63));
    endtask

    task automatic rand_phase(input int n);
        logic [63:0] la, sa;
        for (int i = 0; i < n; i++) begin
            rand_addr(la);
            rand_addr(sa);
            cycle($urandom_range(0, 3) != 0, la,
                  $urandom_range(0, 2) != 0, sa,
                  $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        model_clear();
        do_reset();
        idle(1, 1, 1);
        #1;
        chk("rst_err", error_valid, 1'b0);
        chk("rst_ldrdy", ldaddr_ready, 1'b1);
        chk("rst_strdy", staddr_ready, 1'b1);

        // store then load
        cycle(0, 0, 1, 64'd5, 1, 32'hDEADBEEF, 1, 1, 1);
        #1;
        chk("st5_done", stdone_valid, 1'b1);
        cycle(1, 64'd5, 0, 0, 0, 0, 1, 1, 1);
        #1;
        chk("ld5_data", lddata_data, 32'hDEADBEEF);
        chk("ld5_done", lddone_valid, 1'b1);
        cycle(1, 64'd6, 0, 0, 0, 0, 1, 1, 1);
        #1;
        chk("ld6_data", lddata_data, 32'h0);
        idle(1, 1, 1);

        // load backpressure
        cycle(1, 64'd5, 0, 0, 0, 0, 0, 1, 1);
        idle(0, 1, 1);
        idle(0, 1, 1);
        #1;
        chk("bp_ldv", lddata_valid, 1'b1);
        chk("bp_lddone", lddone_valid, 1'b0);
        chk("bp_lddata", lddata_data, 32'hDEADBEEF);
        chk("bp_ldrdy", ldaddr_ready, 1'b0);
        idle(1, 1, 1);

        // store backpressure
        cycle(0, 0, 1, 64'd7, 1, 32'h77, 1, 1, 0);
        idle(1, 1, 0);
        #1;
        chk("bp_strdy", staddr_ready, 1'b0);
        chk("bp_sdrdy", stdata_ready, 1'b0);
        idle(1, 1, 1);
        idle(1, 1, 1);

        // store pairing
        repeat (4) cycle(0, 0, 1, 64'd9, 0, 32'h99, 1, 1, 1);
        #1;
        chk("pair_nodone", stdone_valid, 1'b0);
        cycle(0, 0, 1, 64'd9, 1, 32'h99, 1, 1, 1);
        cycle(1, 64'd9, 0, 0, 0, 0, 1, 1, 1);
        #1;
        chk("pair_ld9", lddata_data, 32'h99);

        // same-cycle load/store, read-first
        cycle(0, 0, 1, 64'd3, 1, 32'h11, 1, 1, 1);
        cycle(1, 64'd3, 1, 64'd3, 1, 32'h22, 1, 1, 1);
        #1;
        chk("rf_old", lddata_data, 32'h11);
        cycle(1, 64'd3, 0, 0, 0, 0, 1, 1, 1);
        #1;
        chk("rf_new", lddata_data, 32'h22);

        // out of range
        cycle(1, 64'd64, 0, 0, 0, 0, 1, 1, 1);
        #1;
        chk("oob_ld_data", lddata_data, 32'h0);
        chk("oob_ld_done", lddone_valid, 1'b1);
        chk("oob_errv", error_valid, 1'b1);
        chk("oob_errc", error_code, 16'h0001);
        cycle(0, 0, 1, 64'd100, 1, 32'h5A5A, 1, 1, 1);
        #1;
        chk("oob_st_done", stdone_valid, 1'b1);
        chk("oob_errc2", error_code, 16'h0001);
        idle(1, 1, 1);
        do_reset();
        idle(1, 1, 1);
        #1;
        chk("oob_clr", error_valid, 1'b0);

        // store-side error code alone, then random traffic with resets
        cycle(0, 0, 1, {32'h1, 32'h3}, 1, 32'h1, 1, 1, 1);
        #1;
        chk("oob_st_code", error_code, 16'h0002);
        rand_phase(300);
        do_reset();
        rand_phase(300);
        do_reset();
        rand_phase(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_top.md
Name: memory_top

Overview:
- Single-port-per-direction word memory tile in the fabric.
- Accepts load addresses and store address/data pairs on valid/ready streams.
- Returns load data plus per-operation completion tokens (lddone, stdone).
- Reports out-of-range accesses on a sticky error output.

Parameters:
- DEPTH, 64, number of 32-bit words; addresses are word indices (no byte scaling).
- DATA_WIDTH, 32, word width; fixed to match the data ports.
- ADDR_WIDTH, 64, address port width; fixed to match the address ports.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ldaddr_valid / ldaddr_ready / ldaddr_data  in / out / in  1/1/64  load address stream.
- staddr_valid / staddr_ready / staddr_data  in / out / in  1/1/64  store address stream.
- stdata_valid / stdata_ready / stdata_data  in / out / in  1/1/32  store data stream.
- lddata_valid / lddata_ready / lddata_data  out / in / out  1/1/32  load result stream.
- lddone_valid / lddone_ready / lddone_data  out / in / out  1/1/1  load completion token; data is always 0.
- stdone_valid / stdone_ready / stdone_data  out / in / out  1/1/1  store completion token; data is always 0.
- error_valid  output  1  sticky error flag.
- error_code  output  16  code of the first error.

Behaviour:
- Interface is one clock domain. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - All *_valid outputs = 0.
  - lddata_data = 0; lddone_data = 0; stdone_data = 0.
  - error_valid = 0; error_code = 0.
  - All memory words = 0.
  - Reset mid-operation discards all pending responses.
- Handshake:
  - A transfer occurs on a rising edge when valid and ready are both 1.
  - Output valid and data hold stable until accepted.
  - Ready outputs never depend combinationally on their own channel's valid.
- Load path:
  - The load result register and the lddone register are each independently "pending" until their own consumer accepts them.
  - ldaddr_ready = 1 when both are free, or when each pending one is being accepted in the current cycle.
  - On ldaddr fire: mem[addr] is registered into lddata_data; lddata_valid and lddone_valid rise next cycle. Latency is 1 cycle.
  - Each output valid clears independently when its own ready is high.
  - Back-to-back loads sustain 1 per cycle while both readys stay high.
- Store path:
  - Fire requires staddr_valid, stdata_valid, and the stdone slot free or being accepted.
  - staddr_ready = stdata_ready = that slot condition.
  - A store consumes both streams together; neither stream is consumed alone.
  - mem[addr] is written at the fire edge; stdone_valid rises the next cycle.
- Load and store firing in the same cycle to the same address: the load returns the old value (read-first).
- Bounds:
  - An address is in range when addr < DEPTH, compared over the full 64 bits.
  - Out-of-range load: completes normally with lddata_data = 0.
  - Out-of-range store: no write; stdone is still produced.
- Errors:
  - Load out of range → code 16'h0001. Store out of range → code 16'h0002.
  - If both occur in the same cycle, the load code wins.
  - The first error sets error_valid = 1 and latches error_code. Both hold until reset; later errors are ignored.
  - Errors do not stall the streams.

Decomposition:
- Package fabric_mem_pkg:
  - ERR_NONE = 0, ERR_LD_OOB = 1, ERR_ST_OOB = 2 (16-bit).
  - Default DEPTH and DATA_WIDTH.
- One natural sub-module: fabric_out_slot, a 1-entry valid/data output register with accept logic.
  - Instantiated three times (lddata, lddone, stdone).

Test Plan:
- Reset:
  - Hold rst_n=0 for 3 cycles, release, wait 1 cycle → error_valid=0, all *_valid=0, ldaddr_ready=1, staddr_ready=1.
- Store then load:
  - Store addr 5, data 32'hDEADBEEF → stdone_valid 1 cycle later.
  - Load addr 5 → lddata_data=32'hDEADBEEF and lddone_valid=1 one cycle after fire.
  - Load addr 6 → 0.
- Backpressure:
  - lddata_ready=0, lddone_ready=1; load addr 5 → lddone accepted, lddata held stable, ldaddr_ready=0 until lddata_ready=1.
  - Same check for stdone_ready=0 → staddr_ready=stdata_ready=0.
- Store pairing:
  - staddr_valid=1 with stdata_valid=0 for 4 cycles → no write, no stdone, no fire on either stream.
  - Raise stdata_valid → one store fires.
- Out of range:
  - Load addr 64 → lddata=0, lddone produced, error_valid=1, error_code=16'h0001.
  - Then store addr 100 → no write, error_code stays 16'h0001.
  - Reset → error cleared.
- Same-cycle load/store:
  - mem[3]=32'h11; in one cycle load addr 3 and store addr 3 data 32'h22 → load returns 32'h11.
  - Next load of addr 3 returns 32'h22.
